// File: rtl/shift_pkg.sv
// shift_pkg: shared constants and types for the shift_arb slice.
// Provides the requester count, field widths and shift-mode encodings used
// by shift_arb and its barrel shifter.
package shift_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ID_W    = 1;
  localparam int unsigned MUX_W   = 2;
  localparam int unsigned SFT_W   = 5;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned OCC_W   = 2;

  typedef enum logic [MUX_W-1:0] {
    MUX_LSL = 2'b00,
    MUX_LSR = 2'b01,
    MUX_ROL = 2'b10,
    MUX_ASR = 2'b11
  } mux_e;

endpackage

// File: rtl/shift_arb_barrel.sv
// shift_arb_barrel: combinational 32-bit barrel shifter.
// Ports:
//   a   - operand
//   sft - shift count 0..31
//   mux - mode: LSL, LSR, ROL (left rotate), ASR
//   z   - result
module shift_arb_barrel
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [SFT_W-1:0]  sft,
  input  logic [MUX_W-1:0]  mux,
  output logic [DATA_W-1:0] z
);

  logic [2*DATA_W-1:0] rot;

  always_comb begin
    // Rotate: shift the doubled word left, upper half is the rotated value.
    rot = {a, a} << sft;
    z   = a;
    case (mux_e'(mux))
      MUX_LSL: z = a << sft;
      MUX_LSR: z = a >> sft;
      MUX_ROL: z = rot[2*DATA_W-1:DATA_W];
      MUX_ASR: z = $unsigned($signed(a) >>> sft);
      default: z = a;
    endcase
  end

endmodule

// File: rtl/shift_arb.sv
// shift_arb: two requesters sharing one barrel shifter through a two-stage
// pipeline (S1 operand register, S2 result register).
// Ports:
//   sys_clk, rst        - clock, asynchronous active-high reset
//   req_valid/req_ready - per-requester handshake (index 0..1)
//   reqN_mux/sft/a      - per-requester mode, shift count, operand
//   rsp_valid/ready     - response handshake
//   rsp_z, rsp_id       - result and originating requester
//   occupancy           - number of valid pipeline stages (0..2)
// Build option: define SHIFT_ARB_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise requester 0 has fixed priority.
module shift_arb
  import shift_pkg::*;
(
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [MUX_W-1:0]      req0_mux,
  input  logic [MUX_W-1:0]      req1_mux,
  input  logic [SFT_W-1:0]      req0_sft,
  input  logic [SFT_W-1:0]      req1_sft,
  input  logic [DATA_W-1:0]     req0_a,
  input  logic [DATA_W-1:0]     req1_a,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_z,
  output logic [ID_W-1:0]       rsp_id,
  input  logic                  rsp_ready,
  output logic [OCC_W-1:0]      occupancy
);

  logic              s1_valid_q, s1_valid_d;
  logic [MUX_W-1:0]  s1_mux_q,   s1_mux_d;
  logic [SFT_W-1:0]  s1_sft_q,   s1_sft_d;
  logic [DATA_W-1:0] s1_a_q,     s1_a_d;
  logic [ID_W-1:0]   s1_id_q,    s1_id_d;
  logic              s2_valid_q, s2_valid_d;
  logic [DATA_W-1:0] s2_z_q,     s2_z_d;
  logic [ID_W-1:0]   s2_id_q,    s2_id_d;
`ifdef SHIFT_ARB_RR_EN
  logic [ID_W-1:0]   last_q,     last_d;
`endif

  logic              s2_adv;
  logic              s1_adv;
  logic [ID_W-1:0]   gnt_id;
  logic              xfer;
  logic [DATA_W-1:0] s1_z;

  shift_arb_barrel u_barrel (
    .a   (s1_a_q),
    .sft (s1_sft_q),
    .mux (s1_mux_q),
    .z   (s1_z)
  );

  always_comb begin
    s2_adv = !s2_valid_q || rsp_ready;
    s1_adv = !s1_valid_q || s2_adv;

`ifdef SHIFT_ARB_RR_EN
    if (&req_valid) gnt_id = ~last_q;
    else            gnt_id = req_valid[1];
`else
    gnt_id = req_valid[1] & ~req_valid[0];
`endif

    // Ready is forced low during reset even though the stages read empty.
    req_ready = '0;
    if (!rst && s1_adv) req_ready[gnt_id] = 1'b1;
    xfer = |(req_valid & req_ready);

    s1_valid_d = s1_valid_q;
    s1_mux_d   = s1_mux_q;
    s1_sft_d   = s1_sft_q;
    s1_a_d     = s1_a_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_z_d     = s2_z_q;
    s2_id_d    = s2_id_q;
`ifdef SHIFT_ARB_RR_EN
    last_d     = last_q;
    if (xfer) last_d = gnt_id;
`endif

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_z_d  = s1_z;
        s2_id_d = s1_id_q;
      end
    end

    if (s1_adv) begin
      s1_valid_d = xfer;
      if (xfer) begin
        s1_id_d  = gnt_id;
        s1_mux_d = gnt_id[0] ? req1_mux : req0_mux;
        s1_sft_d = gnt_id[0] ? req1_sft : req0_sft;
        s1_a_d   = gnt_id[0] ? req1_a   : req0_a;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_mux_q   <= '0;
      s1_sft_q   <= '0;
      s1_a_q     <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_z_q     <= '0;
      s2_id_q    <= '0;
`ifdef SHIFT_ARB_RR_EN
      last_q     <= '1;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mux_q   <= s1_mux_d;
      s1_sft_q   <= s1_sft_d;
      s1_a_q     <= s1_a_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_z_q     <= s2_z_d;
      s2_id_q    <= s2_id_d;
`ifdef SHIFT_ARB_RR_EN
      last_q     <= last_d;
`endif
    end
  end

  assign rsp_valid = s2_valid_q;
  assign rsp_z     = s2_z_q;
  assign rsp_id    = s2_id_q;
  assign occupancy = {1'b0, s1_valid_q} + {1'b0, s2_valid_q};

endmodule

// File: tb/tb_shift_arb.sv
// tb_shift_arb: self-checking bench for shift_arb with a scoreboard model.
module tb_shift_arb;
  import shift_pkg::*;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [1:0]  req0_mux = '0, req1_mux = '0;
  logic [4:0]  req0_sft = '0, req1_sft = '0;
  logic [31:0] req0_a = '0, req1_a = '0;
  logic        rsp_valid;
  logic [31:0] rsp_z;
  logic [0:0]  rsp_id;
  logic        rsp_ready = 1'b0;
  logic [1:0]  occupancy;

  shift_arb dut (
    .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_mux(req0_mux), .req1_mux(req1_mux), .req0_sft(req0_sft), .req1_sft(req1_sft),
    .req0_a(req0_a), .req1_a(req1_a), .rsp_valid(rsp_valid), .rsp_z(rsp_z),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .occupancy(occupancy)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_checks = 0;
  int          n_fail = 0;
  int          n_rsp = 0;
  logic [32:0] q[$];
  int          xfer_ids[$];
  logic        last_gnt = 1'b1;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_z;
  logic        prev_id;
  logic [31:0] last_rsp_z = '0;
  logic        last_rsp_id = 1'b0;

  function automatic logic [31:0] shift_ref(logic [1:0] mux, logic [4:0] sft, logic [31:0] a);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < int'(sft); i++) begin
      case (mux)
        2'b00:   r = {r[30:0], 1'b0};
        2'b01:   r = {1'b0, r[31:1]};
        2'b10:   r = {r[30:0], r[31]};
        default: r = {r[31], r[31:1]};
      endcase
    end
    return r;
  endfunction

  task automatic clear_model();
    q.delete();
    last_gnt = 1'b1;
    prev_stall = 1'b0;
  endtask

  // One clock cycle: sample mid-cycle, score, then advance the model at the edge.
  task automatic tick();
    logic       any, accept, gnt, fire;
    logic [1:0] exp_rdy;
    logic [32:0] item;
    @(negedge sys_clk); #1;
    any = |req_valid;
    accept = (q.size() < 2) || rsp_ready;
    if (req_valid == 2'b11) begin
`ifdef SHIFT_ARB_RR_EN
      gnt = !last_gnt;
`else
      gnt = 1'b0;
`endif
    end else if (req_valid[0]) gnt = 1'b0;
    else gnt = 1'b1;
    exp_rdy = 2'b00;
    if (any && accept) exp_rdy[gnt] = 1'b1;
    if (any) begin
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_fail++; $display("FAIL req_ready: got %b expected %b", req_ready, exp_rdy);
      end
    end
    n_checks++;
    if (occupancy !== 2'(q.size())) begin
      n_fail++; $display("FAIL occupancy: got %0d expected %0d", occupancy, q.size());
    end
    if (q.size() == 0) begin
      n_checks++;
      if (rsp_valid !== 1'b0) begin
        n_fail++; $display("FAIL rsp_spurious: got rsp_valid=%b z=%h expected 0", rsp_valid, rsp_z);
      end
    end
    if (prev_stall) begin
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_z !== prev_z || rsp_id !== prev_id) begin
        n_fail++;
        $display("FAIL rsp_hold: got v=%b z=%h id=%b expected v=1 z=%h id=%b",
                 rsp_valid, rsp_z, rsp_id, prev_z, prev_id);
      end
    end
    fire = rsp_valid && rsp_ready;
    if (fire && q.size() > 0) begin
      n_checks++;
      if ({rsp_id, rsp_z} !== q[0]) begin
        n_fail++;
        $display("FAIL rsp_data: got id=%b z=%h expected id=%b z=%h", rsp_id, rsp_z, q[0][32], q[0][31:0]);
      end
      last_rsp_z = rsp_z;
      last_rsp_id = rsp_id;
      n_rsp++;
    end
    prev_stall = rsp_valid && !rsp_ready;
    prev_z = rsp_z;
    prev_id = rsp_id;
    item = gnt ? {1'b1, shift_ref(req1_mux, req1_sft, req1_a)}
               : {1'b0, shift_ref(req0_mux, req0_sft, req0_a)};
    @(posedge sys_clk); #1;
    if (fire && q.size() > 0) void'(q.pop_front());
    if (any && accept) begin
      q.push_back(item);
      xfer_ids.push_back(int'(gnt));
      last_gnt = gnt;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;
    clear_model();
    rst = 1'b0;
  endtask

  task automatic issue(input logic id, input logic [1:0] mux, input logic [4:0] sft, input logic [31:0] a);
    rsp_ready = 1'b1;
    if (id) begin req1_mux = mux; req1_sft = sft; req1_a = a; req_valid = 2'b10; end
    else    begin req0_mux = mux; req0_sft = sft; req0_a = a; req_valid = 2'b01; end
    tick();
    req_valid = '0;
    repeat (3) tick();
  endtask

  task automatic randomize_ops();
    req0_mux = 2'($urandom); req1_mux = 2'($urandom);
    req0_sft = 5'($urandom); req1_sft = 5'($urandom);
    req0_a = $urandom;       req1_a = $urandom;
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    while (q.size() > 0 && cnt < 20) begin tick(); cnt++; end
    tick();
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 2'b11;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 2'b00 || occupancy !== 2'd0 || rsp_z !== 32'h0 || rsp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b rdy=%b occ=%0d z=%h id=%b expected 0,00,0,0,0",
               rsp_valid, req_ready, occupancy, rsp_z, rsp_id);
    end
    do_reset();
  endtask

  task automatic test_latency();
    do_reset();
    rsp_ready = 1'b1;
    req0_mux = MUX_LSL; req0_sft = 5'd4; req0_a = 32'h0000_0001;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL latency_t1: got rsp_valid=%b expected 0", rsp_valid);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_z !== 32'h0000_0010 || rsp_id !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_t2: got v=%b z=%h id=%b expected v=1 z=00000010 id=0", rsp_valid, rsp_z, rsp_id);
    end
    drain();
  endtask

  task automatic test_modes();
    logic [31:0] exp_z[3];
    logic [1:0]  mux[3];
    logic [31:0] a[3];
    logic [4:0]  sft[3];
    mux = '{MUX_ASR, MUX_LSR, MUX_ROL};
    a   = '{32'h8000_0000, 32'h8000_0000, 32'h8000_0001};
    sft = '{5'd4, 5'd4, 5'd1};
    exp_z = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0003};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, mux[i], sft[i], a[i]);
      n_checks++;
      if (last_rsp_z !== exp_z[i] || last_rsp_id !== 1'b1) begin
        n_fail++;
        $display("FAIL mode_%0d: got z=%h id=%b expected z=%h id=1", i, last_rsp_z, last_rsp_id, exp_z[i]);
      end
    end
  endtask

  task automatic test_sft0();
    for (int m = 0; m < 4; m++) begin
      issue(1'b0, 2'(m), 5'd0, 32'hDEAD_BEEF);
      n_checks++;
      if (last_rsp_z !== 32'hDEAD_BEEF) begin
        n_fail++; $display("FAIL sft0_mode%0d: got %h expected deadbeef", m, last_rsp_z);
      end
    end
  endtask

  task automatic test_arbitration();
    int exp_id;
    do_reset();
    xfer_ids.delete();
    rsp_ready = 1'b1;
    req0_mux = MUX_LSL; req0_sft = 5'd1; req0_a = 32'h1;
    req1_mux = MUX_LSR; req1_sft = 5'd1; req1_a = 32'h80;
    req_valid = 2'b11;
    repeat (4) tick();
    drain();
    n_checks++;
    if (xfer_ids.size() != 4) begin
      n_fail++; $display("FAIL arb_count: got %0d expected 4", xfer_ids.size());
    end
    for (int i = 0; i < 4 && i < xfer_ids.size(); i++) begin
`ifdef SHIFT_ARB_RR_EN
      exp_id = i % 2;
`else
      exp_id = 0;
`endif
      n_checks++;
      if (xfer_ids[i] != exp_id) begin
        n_fail++; $display("FAIL arb_seq_%0d: got %0d expected %0d", i, xfer_ids[i], exp_id);
      end
    end
  endtask

  task automatic test_backpressure();
    int rsp_before, xfer_before;
    do_reset();
    rsp_before = n_rsp;
    xfer_before = xfer_ids.size();
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin randomize_ops(); tick(); end
    #1;
    n_checks++;
    if (occupancy !== 2'd2 || req_ready !== 2'b00) begin
      n_fail++; $display("FAIL bp_full: got occ=%0d rdy=%b expected occ=2 rdy=00", occupancy, req_ready);
    end
    drain();
    n_checks++;
    if (n_rsp - rsp_before != xfer_ids.size() - xfer_before || n_rsp - rsp_before != 2) begin
      n_fail++;
      $display("FAIL bp_count: got %0d responses for %0d transfers expected 2 and 2",
               n_rsp - rsp_before, xfer_ids.size() - xfer_before);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    rsp_ready = 1'b0;
    req_valid = 2'b11;
    randomize_ops();
    repeat (3) tick();
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || occupancy !== 2'd0 || req_ready !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_async: got v=%b occ=%0d rdy=%b expected 0,0,00", rsp_valid, occupancy, req_ready);
    end
    clear_model();
    @(posedge sys_clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    req0_mux = MUX_ROL; req0_sft = 5'd8; req0_a = 32'h1234_5678;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    drain();
    n_checks++;
    if (last_rsp_z !== 32'h3456_7812) begin
      n_fail++; $display("FAIL reset_first_req: got %h expected 34567812", last_rsp_z);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      randomize_ops();
      tick();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_modes();
    test_sft0();
    test_arbitration();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
